axi_gp_master_seq: RTL and testbench
====================================

Name: axi_gp_master_seq

Overview:
- Two-requester sequencer driving the PS-side AXI3 GP register port, issuing single-beat transactions only.
- Accepts simple read/write commands from two internal requesters, e.g. a command engine and a debug/status poller.
- Arbitrates between them round-robin and runs the AW/W/B or AR/R handshakes.
- Returns data and response to the granted requester.
- Burst attributes are tied at top level: LEN=0, SIZE=2'b10, BURST=INCR, WLAST=1, IDs=0.

Parameters:
ADDR_BASE, 32'h0, added to the word-aligned request address to form AWADDR/ARADDR
TIMEOUT_CYCLES, 256, watchdog limit per transaction (used only with AXI_TIMEOUT_EN)

Ports:
ACLK  input  1  clock
ARESETN  input  1  synchronous active-low reset
req_valid  input  2  per-requester command valid
req_ready  output  2  one-hot one-cycle accept pulse
req_we  input  2  per-requester 1=write, 0=read
req_addr  input  64  {req1,req0} byte addresses; bits [1:0] ignored
req_wdata  input  64  {req1,req0} write data
req_wstrb  input  8  {req1,req0} byte strobes
rsp_valid  output  2  one-hot one-cycle completion pulse
rsp_rdata  output  32  read data, valid with rsp_valid
rsp_resp  output  2  BRESP/RRESP, or 2'b11 on timeout
AWADDR  output  32  write address
AWVALID  output  1  write address valid
AWREADY  input  1  write address ready
WDATA  output  32  write data
WSTRB  output  4  write strobes
WVALID  output  1  write data valid
WREADY  input  1  write data ready
BVALID  input  1  write response valid
BREADY  output  1  write response ready
BRESP  input  2  write response
ARADDR  output  32  read address
ARVALID  output  1  read address valid
ARREADY  input  1  read address ready
RDATA  input  32  read data
RVALID  input  1  read data valid
RREADY  output  1  read data ready
RRESP  input  2  read response

Behaviour:
- Reset (ARESETN=0 at posedge ACLK):
  - All outputs go to 0; state goes to IDLE.
  - Round-robin pointer set so req0 wins the first contention.
  - This applies mid-transaction as well: valids drop on the next edge and no rsp_valid is issued.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If any req_valid is set, grant one requester.
  - If only one is valid, grant it. If both are valid, grant the requester not granted last.
  - Pulse req_ready[g] for that cycle and latch addr/wdata/wstrb/we of requester g.
  - Go to WADDR if we=1, otherwise RADDR.
- WADDR:
  - AWVALID and WVALID both assert on the first WADDR cycle with latched values; AWADDR = ADDR_BASE + {addr[31:2],2'b00}.
  - Each valid deasserts on the cycle after its own handshake (VALID&READY sampled at posedge).
  - The two handshakes may complete in either order or together.
  - When both are done, go to WRESP with BREADY=1.
  - AWADDR/WDATA/WSTRB hold stable while their valid is high.
- WRESP: on BVALID, capture BRESP, drop BREADY, go to RESP.
- RADDR: ARVALID=1 until ARREADY; then go to RDATA with RREADY=1.
- RDATA: on RVALID, capture RDATA/RRESP, drop RREADY, go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle; rsp_rdata/rsp_resp are valid in that cycle.
  - rsp_rdata holds its value until the next read completes; it is 0 after a write.
  - Return to IDLE. A new grant is possible in the cycle after RESP.
- Minimum latency with zero-wait slave: req accept to rsp_valid = 4 cycles (write), 4 cycles (read).
- A requester whose req_valid drops before grant is not served. req_valid held after grant is treated as a new command.

Optional Feature:
- Macro AXI_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WADDR/WRESP/RADDR/RDATA and clears on entering IDLE.
  - When the counter reaches TIMEOUT_CYCLES, all AXI valid/ready outputs drop on the next edge.
  - rsp_resp=2'b11 and rsp_rdata=0 via RESP, then IDLE.
  - Late slave responses are ignored; recovery requires ARESETN.
- When undefined: no counter, no timeout path, and the block waits indefinitely.

Test Plan:
1. req0 write addr 0x4, data 0xdeadbeef, strb 4'b1011; AWREADY after 3 cycles, WREADY immediate; BRESP=00 -> AWADDR=0x4 held 3 cycles, WVALID high 1 cycle, BREADY until BVALID, rsp_valid=2'b01, rsp_resp=00.
2. req1 read addr 0x7; slave returns RDATA 0xdeadbeef, RRESP=00 -> ARADDR=0x4, rsp_valid=2'b10, rsp_rdata=0xdeadbeef.
3. Both requesters hold req_valid with 4 reads each -> grant order 0,1,0,1,... and req_ready is never two-hot.
4. Write with BRESP=2'b10, then read with RRESP=2'b11 -> rsp_resp 10 then 11, each with the correct rsp_valid bit.
5. ARESETN low for one cycle while in WRESP -> next cycle BREADY=0, no rsp_valid; next request starts cleanly from IDLE with req0 priority.
6. With AXI_TIMEOUT_EN, AWREADY stuck 0 -> AWVALID drops after 256 cycles, rsp_resp=2'b11, rsp_rdata=0.

Source files
------------

// File: rtl/axi_gp_master_seq_if.sv
// AXI3 GP register-port signal bundle (single-beat subset) used by axi_gp_master_seq.
// The master modport drives addresses, data and valids; the slave modport answers.
interface axi_gp_master_seq_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic [1:0]  RRESP;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RVALID, RRESP
    );
endinterface

// File: rtl/axi_gp_master_seq.sv
// Two-requester round-robin sequencer issuing single-beat AXI3 GP transactions.
// Optional watchdog enabled by defining AXI_TIMEOUT_EN.
module axi_gp_master_seq #(
    parameter logic [31:0] ADDR_BASE      = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [63:0]         req_addr,
    input  logic [63:0]         req_wdata,
    input  logic [7:0]          req_wstrb,
    output logic [1:0]          rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic [1:0]          rsp_resp,
    axi_gp_master_seq_if.master axi
);

    typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StResp} state_e;

    state_e      state_q;
    logic        last_q;
    logic        cur_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, rsp_rdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [1:0]  rsp_valid_q, rsp_resp_q;

    logic [1:0]  gnt;
    logic        sel_we;
    logic [29:0] sel_word;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic [1:0]  cur_oh;
    logic        aw_pending, w_pending;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[33:32], req_addr[1:0]};

    // last_q holds the index granted most recently; contention goes to the other one.
    always_comb begin
        gnt = 2'b00;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        sel_we    = gnt[1] ? req_we[1]          : req_we[0];
        sel_word  = gnt[1] ? req_addr[63:34]    : req_addr[31:2];
        sel_wdata = gnt[1] ? req_wdata[63:32]   : req_wdata[31:0];
        sel_wstrb = gnt[1] ? req_wstrb[7:4]     : req_wstrb[3:0];
    end

    assign req_ready  = (ARESETN && state_q == StIdle) ? gnt : 2'b00;
    assign cur_oh     = cur_q ? 2'b10 : 2'b01;
    assign aw_pending = awvalid_q && !axi.AWREADY;
    assign w_pending  = wvalid_q && !axi.WREADY;

`ifdef AXI_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q;
    logic            active;
    assign active = (state_q == StWaddr) || (state_q == StWresp) ||
                    (state_q == StRaddr) || (state_q == StRdata);
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cur_q       <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
`ifdef AXI_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        last_q <= gnt[1];
                        cur_q  <= gnt[1];
                        if (sel_we) begin
                            awaddr_q  <= ADDR_BASE + {sel_word, 2'b00};
                            wdata_q   <= sel_wdata;
                            wstrb_q   <= sel_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWaddr;
                        end else begin
                            araddr_q  <= ADDR_BASE + {sel_word, 2'b00};
                            arvalid_q <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end
                end
                StWaddr: begin
                    if (axi.AWREADY) awvalid_q <= 1'b0;
                    if (axi.WREADY)  wvalid_q  <= 1'b0;
                    if (!aw_pending && !w_pending) begin
                        bready_q <= 1'b1;
                        state_q  <= StWresp;
                    end
                end
                StWresp: begin
                    if (axi.BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= axi.BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= cur_oh;
                        state_q     <= StResp;
                    end
                end
                StRaddr: begin
                    if (axi.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (axi.RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= axi.RRESP;
                        rsp_rdata_q <= axi.RDATA;
                        rsp_valid_q <= cur_oh;
                        state_q     <= StResp;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
`ifdef AXI_TIMEOUT_EN
            // Counter value equals cycles already spent; expiry overrides any handshake.
            if (active) begin
                if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    awvalid_q   <= 1'b0;
                    wvalid_q    <= 1'b0;
                    bready_q    <= 1'b0;
                    arvalid_q   <= 1'b0;
                    rready_q    <= 1'b0;
                    rsp_resp_q  <= 2'b11;
                    rsp_rdata_q <= '0;
                    rsp_valid_q <= cur_oh;
                    state_q     <= StResp;
                    tmo_cnt_q   <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end else begin
                tmo_cnt_q <= '0;
            end
`endif
        end
    end

    assign axi.AWADDR  = awaddr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;

endmodule

// File: tb/tb_axi_gp_master_seq.sv
// Directed bench for axi_gp_master_seq: configurable-wait slave, negedge monitor,
// one task per scenario. Timeout scenario compiled only with AXI_TIMEOUT_EN.
module tb_axi_gp_master_seq;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [3:0]  st0 = '0, st1 = '0;
    logic [1:0]  req_ready, rsp_valid, rsp_resp;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;

    axi_gp_master_seq_if axi ();

    axi_gp_master_seq #(
        .ADDR_BASE      (32'h0),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid ({v1, v0}),
        .req_ready (req_ready),
        .req_we    ({we1, we0}),
        .req_addr  ({addr1, addr0}),
        .req_wdata ({wd1, wd0}),
        .req_wstrb ({st1, st0}),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    // Slave: each ready/valid rises after N cycles of the master's valid/ready.
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;

    always @(negedge ACLK) begin
        if (axi.AWVALID) begin axi.AWREADY = (aw_c >= aw_wait); aw_c++; end
        else begin axi.AWREADY = 1'b0; aw_c = 0; end
        if (axi.WVALID) begin axi.WREADY = (w_c >= w_wait); w_c++; end
        else begin axi.WREADY = 1'b0; w_c = 0; end
        axi.BRESP = bresp_cfg;
        if (axi.BREADY) begin axi.BVALID = (b_c >= b_wait); b_c++; end
        else begin axi.BVALID = 1'b0; b_c = 0; end
        if (axi.ARVALID) begin axi.ARREADY = (ar_c >= ar_wait); ar_c++; end
        else begin axi.ARREADY = 1'b0; ar_c = 0; end
        axi.RDATA = rdata_cfg;
        axi.RRESP = rresp_cfg;
        if (axi.RREADY) begin axi.RVALID = (r_c >= r_wait); r_c++; end
        else begin axi.RVALID = 1'b0; r_c = 0; end
    end

    // Monitor: cumulative counters and logs; tasks work with deltas from snapshots.
    int          awv_cnt = 0, wv_cnt = 0, br_cnt = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, prev_awaddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        aw_was = 1'b0, aw_unstable = 1'b0, two_hot = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_resp = '0;
    int          gnt_q[$];
    logic [1:0]  rsp_q[$];

    always @(negedge ACLK) begin
        #2;
        if (axi.AWVALID) begin
            awv_cnt++;
            if (aw_was && axi.AWADDR !== prev_awaddr) aw_unstable = 1'b1;
            prev_awaddr = axi.AWADDR;
            last_awaddr = axi.AWADDR;
        end
        aw_was = axi.AWVALID;
        if (axi.WVALID) begin
            wv_cnt++;
            last_wdata = axi.WDATA;
            last_wstrb = axi.WSTRB;
        end
        if (axi.BREADY) br_cnt++;
        if (axi.ARVALID) last_araddr = axi.ARADDR;
        if (req_ready == 2'b11) two_hot = 1'b1;
        if (req_ready == 2'b01) gnt_q.push_back(0);
        if (req_ready == 2'b10) gnt_q.push_back(1);
        if (rsp_valid != 2'b00) begin
            rsp_q.push_back(rsp_valid);
            last_rdata = rsp_rdata;
            last_resp  = rsp_resp;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Holds req_valid until n accepts are seen (or the budget expires).
    task automatic drive_req(input int idx, input int n, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, output int acc);
        acc = 0;
        @(negedge ACLK);
        if (idx == 0) begin v0 = 1'b1; we0 = we; addr0 = a; wd0 = d; st0 = s; end
        else          begin v1 = 1'b1; we1 = we; addr1 = a; wd1 = d; st1 = s; end
        for (int c = 0; c < 400 && acc < n; c++) begin
            #1;
            if (req_ready[idx]) acc++;
            @(negedge ACLK);
        end
        if (idx == 0) v0 = 1'b0;
        else          v1 = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge ACLK);
            #3;
            if (rsp_q.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        v0 = 1'b1;
        idle(3);
        #3;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        total++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY} !== 5'b0) begin
            bad++; $display("FAIL reset_axi_valids got=%b want=00000",
                            {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}); end
        total++; if ({rsp_valid, rsp_resp, rsp_rdata} !== 36'h0) begin
            bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_valid, rsp_resp, rsp_rdata}); end
        total++; if ({axi.AWADDR, axi.ARADDR} !== 64'h0) begin
            bad++; $display("FAIL reset_addr got=%h want=0", {axi.AWADDR, axi.ARADDR}); end
        v0 = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        idle(1);
    endtask

    task automatic test_write_basic();
        int acc, awv0, wv0, br0, rs;
        bit ok;
        aw_wait = 2; w_wait = 0; b_wait = 1; bresp_cfg = 2'b00;
        awv0 = awv_cnt; wv0 = wv_cnt; br0 = br_cnt; rs = rsp_q.size();
        drive_req(0, 1, 1'b1, 32'h4, 32'hdeadbeef, 4'b1011, acc);
        wait_rsp(rs + 1, 50, ok);
        idle(3);
        total++; if (!(acc == 1 && ok)) begin bad++; $display("FAIL wr_done got acc=%0d ok=%0d want 1 1", acc, ok); end
        total++; if (awv_cnt - awv0 != 3) begin bad++; $display("FAIL wr_awvalid_cycles got=%0d want=3", awv_cnt - awv0); end
        total++; if (wv_cnt - wv0 != 1) begin bad++; $display("FAIL wr_wvalid_cycles got=%0d want=1", wv_cnt - wv0); end
        total++; if (br_cnt - br0 != 2) begin bad++; $display("FAIL wr_bready_cycles got=%0d want=2", br_cnt - br0); end
        total++; if (last_awaddr !== 32'h4 || aw_unstable) begin
            bad++; $display("FAIL wr_awaddr got=%h unstable=%0d want=00000004 0", last_awaddr, aw_unstable); end
        total++; if (last_wdata !== 32'hdeadbeef || last_wstrb !== 4'b1011) begin
            bad++; $display("FAIL wr_wdata got=%h/%b want=deadbeef/1011", last_wdata, last_wstrb); end
        total++; if (rsp_q.size() != rs + 1 || rsp_q[rs] !== 2'b01) begin
            bad++; $display("FAIL wr_rsp_valid got n=%0d v=%b want n=%0d v=01", rsp_q.size() - rs, rsp_q[rs], 1); end
        total++; if (last_resp !== 2'b00 || last_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_rsp_data got=%b/%h want=00/00000000", last_resp, last_rdata); end
    endtask

    task automatic test_read_basic();
        int acc, rs, gs;
        bit ok;
        ar_wait = 1; r_wait = 2; rdata_cfg = 32'hdeadbeef; rresp_cfg = 2'b00;
        rs = rsp_q.size(); gs = gnt_q.size();
        drive_req(1, 1, 1'b0, 32'h7, 32'h0, 4'h0, acc);
        wait_rsp(rs + 1, 50, ok);
        idle(3);
        total++; if (!(acc == 1 && ok)) begin bad++; $display("FAIL rd_done got acc=%0d ok=%0d want 1 1", acc, ok); end
        total++; if (gnt_q[gs] != 1) begin bad++; $display("FAIL rd_grant got=%0d want=1", gnt_q[gs]); end
        total++; if (last_araddr !== 32'h4) begin bad++; $display("FAIL rd_araddr got=%h want=00000004", last_araddr); end
        total++; if (rsp_q[rs] !== 2'b10 || last_rdata !== 32'hdeadbeef || last_resp !== 2'b00) begin
            bad++; $display("FAIL rd_rsp got=%b/%h/%b want=10/deadbeef/00", rsp_q[rs], last_rdata, last_resp); end
        total++; if (rsp_rdata !== 32'hdeadbeef) begin bad++; $display("FAIL rd_rdata_hold got=%h want=deadbeef", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, rs, gs;
        bit ok;
        ar_wait = 0; r_wait = 0; rdata_cfg = 32'h12345678;
        rs = rsp_q.size(); gs = gnt_q.size();
        fork
            drive_req(0, 4, 1'b0, 32'h10, 32'h0, 4'h0, acc0);
            drive_req(1, 4, 1'b0, 32'h20, 32'h0, 4'h0, acc1);
        join
        wait_rsp(rs + 8, 100, ok);
        idle(3);
        total++; if (!(acc0 == 4 && acc1 == 4 && ok)) begin
            bad++; $display("FAIL b2b_done got acc0=%0d acc1=%0d ok=%0d want 4 4 1", acc0, acc1, ok); end
        for (int i = 0; i < 8; i++) begin
            total++; if (gnt_q[gs+i] != i % 2) begin
                bad++; $display("FAIL b2b_grant[%0d] got=%0d want=%0d", i, gnt_q[gs+i], i % 2); end
            total++; if (rsp_q[rs+i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL b2b_rsp[%0d] got=%b want=%0d", i, rsp_q[rs+i], (i % 2 == 1) ? 10 : 1); end
        end
        total++; if (two_hot) begin bad++; $display("FAIL b2b_two_hot got=1 want=0"); end
        total++; if (last_araddr !== 32'h20) begin bad++; $display("FAIL b2b_araddr got=%h want=00000020", last_araddr); end
    endtask

    task automatic test_error_resp();
        int acc, rs, awv0, wv0;
        bit ok;
        aw_wait = 0; w_wait = 2; b_wait = 0; bresp_cfg = 2'b10;
        rs = rsp_q.size(); awv0 = awv_cnt; wv0 = wv_cnt;
        drive_req(0, 1, 1'b1, 32'h8, 32'h01020304, 4'hf, acc);
        wait_rsp(rs + 1, 50, ok);
        total++; if (!(acc == 1 && ok)) begin bad++; $display("FAIL err_wr_done got acc=%0d ok=%0d want 1 1", acc, ok); end
        total++; if (awv_cnt - awv0 != 1 || wv_cnt - wv0 != 3) begin
            bad++; $display("FAIL err_wr_valid_cycles got aw=%0d w=%0d want 1 3", awv_cnt - awv0, wv_cnt - wv0); end
        total++; if (rsp_q[rs] !== 2'b01 || last_resp !== 2'b10) begin
            bad++; $display("FAIL err_wr_rsp got=%b/%b want=01/10", rsp_q[rs], last_resp); end
        idle(2);
        ar_wait = 0; r_wait = 0; rresp_cfg = 2'b11; rdata_cfg = 32'hcafef00d;
        drive_req(1, 1, 1'b0, 32'hc, 32'h0, 4'h0, acc);
        wait_rsp(rs + 2, 50, ok);
        idle(2);
        total++; if (!(acc == 1 && ok)) begin bad++; $display("FAIL err_rd_done got acc=%0d ok=%0d want 1 1", acc, ok); end
        total++; if (rsp_q[rs+1] !== 2'b10 || last_resp !== 2'b11 || last_rdata !== 32'hcafef00d) begin
            bad++; $display("FAIL err_rd_rsp got=%b/%b/%h want=10/11/cafef00d", rsp_q[rs+1], last_resp, last_rdata); end
        rresp_cfg = 2'b00; bresp_cfg = 2'b00; w_wait = 0;
    endtask

    // Cycles counted inclusively: grant (IDLE), two handshake cycles, then RESP.
    task automatic test_latency(input logic we);
        int  lat;
        bit  got;
        logic rdy;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        @(negedge ACLK);
        v0 = 1'b1; we0 = we; addr0 = 32'h14; wd0 = 32'h0badf00d; st0 = 4'hf;
        #1;
        rdy = req_ready[0];
        lat = 1; got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge ACLK);
            v0 = 1'b0;
            lat++;
            #3;
            if (rsp_valid != 2'b00) got = 1'b1;
        end
        idle(2);
        total++; if (!(rdy && got && lat == 4)) begin
            bad++; $display("FAIL latency_we%0d got rdy=%0d got=%0d lat=%0d want 1 1 4", we, rdy, got, lat); end
    endtask

    task automatic test_reset_mid();
        int acc, acc0, acc1, rs, gs;
        bit seen, ok;
        aw_wait = 0; w_wait = 0; b_wait = 20;
        rs = rsp_q.size();
        drive_req(0, 1, 1'b1, 32'h30, 32'h5555aaaa, 4'hf, acc);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (axi.BREADY) begin seen = 1'b1; break; end
            @(negedge ACLK);
        end
        total++; if (!(acc == 1 && seen)) begin bad++; $display("FAIL rst_reach_wresp got acc=%0d seen=%0d want 1 1", acc, seen); end
        ARESETN = 1'b0;
        @(negedge ACLK);
        #3;
        total++; if ({axi.BREADY, axi.AWVALID, axi.WVALID, rsp_valid} !== 5'b0) begin
            bad++; $display("FAIL rst_outputs got=%b want=00000", {axi.BREADY, axi.AWVALID, axi.WVALID, rsp_valid}); end
        ARESETN = 1'b1;
        idle(5);
        total++; if (rsp_q.size() != rs) begin bad++; $display("FAIL rst_no_rsp got=%0d want=0", rsp_q.size() - rs); end
        b_wait = 0; ar_wait = 0; r_wait = 0;
        gs = gnt_q.size();
        fork
            drive_req(0, 1, 1'b0, 32'h50, 32'h0, 4'h0, acc0);
            drive_req(1, 1, 1'b0, 32'h60, 32'h0, 4'h0, acc1);
        join
        wait_rsp(rs + 2, 50, ok);
        idle(2);
        total++; if (!(acc0 == 1 && acc1 == 1 && ok)) begin
            bad++; $display("FAIL rst_after_done got acc0=%0d acc1=%0d ok=%0d want 1 1 1", acc0, acc1, ok); end
        total++; if (gnt_q[gs] != 0 || gnt_q[gs+1] != 1 || rsp_q[rs] !== 2'b01) begin
            bad++; $display("FAIL rst_priority got g=%0d,%0d r=%b want 0,1 01", gnt_q[gs], gnt_q[gs+1], rsp_q[rs]); end
    endtask

`ifdef AXI_TIMEOUT_EN
    task automatic test_timeout();
        int acc, rs, awv0;
        bit ok;
        aw_wait = 100000; w_wait = 0; b_wait = 0;
        rs = rsp_q.size(); awv0 = awv_cnt;
        drive_req(0, 1, 1'b1, 32'h40, 32'h11111111, 4'hf, acc);
        wait_rsp(rs + 1, 400, ok);
        idle(2);
        total++; if (!(acc == 1 && ok)) begin bad++; $display("FAIL tmo_done got acc=%0d ok=%0d want 1 1", acc, ok); end
        total++; if (awv_cnt - awv0 != 256) begin bad++; $display("FAIL tmo_awvalid_cycles got=%0d want=256", awv_cnt - awv0); end
        total++; if (rsp_q[rs] !== 2'b01 || last_resp !== 2'b11 || last_rdata !== 32'h0) begin
            bad++; $display("FAIL tmo_rsp got=%b/%b/%h want=01/11/00000000", rsp_q[rs], last_resp, last_rdata); end
        aw_wait = 0;
        ARESETN = 1'b0;
        idle(1);
        ARESETN = 1'b1;
        idle(1);
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_error_resp();
        test_latency(1'b1);
        test_latency(1'b0);
        test_reset_mid();
`ifdef AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

endmodule
